vedic_mul_arbiter: RTL



---
 rtl/vedic_pkg.sv | 49 ++++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/vedic_8x8.sv | 52 +++++
 rtl/vedic_mul_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vedic_pkg
// Description : Shared widths, FSM state type and round-robin search helper
//               for the shared vedic multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

    localparam int OP_W     = 8;
    localparam int PROD_W   = 16;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    // Output slot occupancy
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    // One-hot round-robin pick: first set bit of valid at or after last+1,
    // wrapping within the first num positions.
    function automatic logic [MAX_REQ-1:0] rr_next(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] last,
        input int                  num
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if ((k <= num) && !found) begin
                idx = int'(last) + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (valid[idx[MAX_ID_W-1:0]]) begin
                    gnt[idx[MAX_ID_W-1:0]] = 1'b1;
                    found                  = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches req starting one
//               past last_gnt and returns one-hot and encoded grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import vedic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [ID_W-1:0]    last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic [MAX_REQ-1:0]  w_req_ext;
    logic [MAX_ID_W-1:0] w_last_ext;
    logic [MAX_REQ-1:0]  w_onehot;
    logic                w_unused_hi;

    // Widen to the package search width and pick the next requester
    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = req;
        w_last_ext               = '0;
        w_last_ext[ID_W-1:0]     = last_gnt;
        w_onehot                 = rr_next(w_req_ext, w_last_ext, NUM_REQ);
    end

    // Bits above NUM_REQ are always zero from the search
    assign w_unused_hi = ^w_onehot;

    // Gate grant with enable and encode the winning index
    always_comb begin
        gnt    = enable ? w_onehot[NUM_REQ-1:0] : '0;
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vedic_8x8.sv
`default_nettype none
// ============================================================================
// Module      : vedic_8x8
// Description : Unsigned 8x8 multiplier built hierarchically from 2x2 Urdhva
//               Tiryagbhyam cells (2x2 -> 4x4 -> 8x8), purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // 2x2 cell: vertical and crosswise partial products with half adders
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic c1;
        logic t;
        mul2[0] = x[0] & y[0];
        mul2[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1      = (x[1] & y[0]) & (x[0] & y[1]);
        t       = x[1] & y[1];
        mul2[2] = t ^ c1;
        mul2[3] = t & c1;
    endfunction

    // 4x4 from four 2x2 cells; outer products never overlap so they concatenate
    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r0, r1, r2, r3;
        logic [7:0] mid;
        r0   = mul2(x[1:0], y[1:0]);
        r1   = mul2(x[3:2], y[1:0]);
        r2   = mul2(x[1:0], y[3:2]);
        r3   = mul2(x[3:2], y[3:2]);
        mid  = {4'b0, r1} + {4'b0, r2};
        mul4 = {r3, r0} + (mid << 2);
    endfunction

    logic [7:0]  w_q0;
    logic [7:0]  w_q1;
    logic [7:0]  w_q2;
    logic [7:0]  w_q3;
    logic [15:0] w_mid;

    assign w_q0  = mul4(a[3:0], b[3:0]);
    assign w_q1  = mul4(a[7:4], b[3:0]);
    assign w_q2  = mul4(a[3:0], b[7:4]);
    assign w_q3  = mul4(a[7:4], b[7:4]);
    assign w_mid = {8'b0, w_q1} + {8'b0, w_q2};
    assign p     = {w_q3, w_q0} + (w_mid << 4);

endmodule
`default_nettype wire

// File: rtl/vedic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vedic_mul_arbiter
// Description : Shares one vedic_8x8 multiplier among NUM_REQ requesters via
//               round-robin valid/ready grants; returns the tagged 16-bit
//               product through a registered, back-pressurable response slot.
//               Optional macro VEDIC_ARB_PIPE_EN inserts an operand register
//               stage ahead of the multiplier (latency 2 instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_mul_arbiter
    import vedic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [PROD_W-1:0]       rsp_product,
    input  logic                    rsp_ready
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_last_gnt;
    logic [ID_W-1:0]     r_rsp_id;
    logic [PROD_W-1:0]   r_rsp_product;

    logic                w_advance;
    logic                w_arb_en;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_accept;
    logic [OP_W-1:0]     w_op_a;
    logic [OP_W-1:0]     w_op_b;
    logic [OP_W-1:0]     w_mul_a;
    logic [OP_W-1:0]     w_mul_b;
    logic [PROD_W-1:0]   w_prod;
    logic                w_load;
    logic [ID_W-1:0]     w_load_id;

    // Only a full slot that the consumer refuses stalls the datapath
    assign w_advance = (r_state == IDLE) || rsp_ready;
    assign w_arb_en  = w_advance && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req_valid),
        .enable   (w_arb_en),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt),
        .gnt_id   (w_gnt_id)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;

    // AND-OR operand mux on the one-hot grant
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_op_a = req_a[i*OP_W +: OP_W];
                w_op_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

`ifdef VEDIC_ARB_PIPE_EN
    logic              r_s0_valid;
    logic [OP_W-1:0]   r_s0_a;
    logic [OP_W-1:0]   r_s0_b;
    logic [ID_W-1:0]   r_s0_id;

    // Operand stage: captures the granted pair, frozen during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_a     <= '0;
            r_s0_b     <= '0;
            r_s0_id    <= '0;
        end else if (w_advance) begin
            r_s0_valid <= w_accept;
            r_s0_a     <= w_op_a;
            r_s0_b     <= w_op_b;
            r_s0_id    <= w_gnt_id;
        end
    end

    assign w_mul_a   = r_s0_a;
    assign w_mul_b   = r_s0_b;
    assign w_load    = r_s0_valid;
    assign w_load_id = r_s0_id;
`else
    assign w_mul_a   = w_op_a;
    assign w_mul_b   = w_op_b;
    assign w_load    = w_accept;
    assign w_load_id = w_gnt_id;
`endif

    vedic_8x8 u_mul (
        .a (w_mul_a),
        .b (w_mul_b),
        .p (w_prod)
    );

    // Round-robin pointer moves only when a request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last_gnt <= w_gnt_id;
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot fills when a product arrives, empties when drained with none behind it
    always_comb begin
        w_state_nxt = r_state;
        if (w_advance) begin
            w_state_nxt = w_load ? FULL : IDLE;
        end
    end

    // Response payload register, held stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else if (w_advance && w_load) begin
            r_rsp_id      <= w_load_id;
            r_rsp_product <= w_prod;
        end
    end

    assign rsp_valid   = (r_state == FULL);
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;

endmodule
`default_nettype wire
